// File: rtl/serial_rx_packetizer.sv
// Byte-stream deframer: hunts SYNC_BYTE, parses LEN/payload/CHK, and releases only checksum-verified payload.
// Latency: pkt_ok/pkt_err one cycle after the CHK/LEN strobe or gap pulse; first payload byte visible with pkt_ok.
// Backpressure: none toward rx (one byte per cycle always consumed); out side is valid/ready, one byte per cycle.
// Ports: clk, rst (sync, active-high); rx_valid/rx_data/rx_endofpacket from the UART receiver;
//        out_valid/out_ready/out_data/out_last toward the consumer; pkt_ok/pkt_err/err_code status; busy = not hunting.
module serial_rx_packetizer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         DEPTH     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_endofpacket,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  // Compare width wide enough for both LEN (0..255) and free space (0..DEPTH).
  localparam int CW = (AW + 2 > 9) ? AW + 2 : 9;

  typedef enum logic [2:0] {S_HUNT, S_LENGTH, S_PAYLOAD, S_CHECK, S_DROP} state_t;

  state_t      state, next_state;
  logic [AW:0] rd_ptr, wr_tent, wr_commit;
  logic [8:0]  cnt;
  logic [7:0]  sum;
  logic [8:0]  mem [DEPTH];
  logic [8:0]  head;

  logic [AW:0]   used;
  logic [AW+1:0] free_space;
  logic          len_too_big;
  logic          gap_abort;

  // Action strobes decoded from state and inputs.
  logic       load_len, mem_we, cnt_dec, do_commit, do_rollback, err_set;
  logic [1:0] err_code_d;

  // Only committed-but-unread entries occupy space; tentative bytes are
  // covered because they are written after the admission check.
  assign used        = wr_commit - rd_ptr;
  assign free_space  = (AW+2)'(DEPTH) - {1'b0, used};
  assign len_too_big = CW'(rx_data) > CW'(free_space);
  assign gap_abort   = rx_endofpacket && (state != S_HUNT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_HUNT;
    else     state <= next_state;
  end

  // Next-state logic; gap abort overrides any same-cycle byte.
  always_comb begin
    next_state = state;
    if (gap_abort) begin
      next_state = S_HUNT;
    end else if (rx_valid) begin
      case (state)
        S_HUNT:    if (rx_data == SYNC_BYTE) next_state = S_LENGTH;
        S_LENGTH: begin
          if (len_too_big)          next_state = S_DROP;
          else if (rx_data == 8'd0) next_state = S_CHECK;
          else                      next_state = S_PAYLOAD;
        end
        S_PAYLOAD: if (cnt == 9'd1) next_state = S_CHECK;
        S_CHECK:   next_state = S_HUNT;
        S_DROP:    if (cnt == 9'd1) next_state = S_HUNT;
        default:   next_state = S_HUNT;
      endcase
    end
  end

  // Output / action decode
  always_comb begin
    load_len    = 1'b0;
    mem_we      = 1'b0;
    cnt_dec     = 1'b0;
    do_commit   = 1'b0;
    do_rollback = 1'b0;
    err_set     = 1'b0;
    err_code_d  = 2'b00;
    if (gap_abort) begin
      do_rollback = 1'b1;
      err_set     = 1'b1;
      err_code_d  = 2'b11;
    end else if (rx_valid) begin
      case (state)
        S_LENGTH: begin
          load_len = 1'b1;
          if (len_too_big) begin
            err_set    = 1'b1;
            err_code_d = 2'b10;
          end
        end
        S_PAYLOAD: begin
          mem_we  = 1'b1;
          cnt_dec = 1'b1;
        end
        S_CHECK: begin
          if (rx_data == sum) begin
            do_commit = 1'b1;
          end else begin
            do_rollback = 1'b1;
            err_set     = 1'b1;
            err_code_d  = 2'b01;
          end
        end
        S_DROP:  cnt_dec = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath: counters, pointers, status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_tent   <= '0;
      wr_commit <= '0;
      cnt       <= '0;
      sum       <= '0;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      pkt_ok  <= do_commit;
      pkt_err <= err_set;
      if (err_set) err_code <= err_code_d;
      if (load_len) begin
        // Dropped frames also swallow their CHK byte, hence LEN+1.
        cnt <= len_too_big ? ({1'b0, rx_data} + 9'd1) : {1'b0, rx_data};
        sum <= rx_data;
      end
      if (mem_we) begin
        wr_tent <= wr_tent + 1'b1;
        sum     <= sum + rx_data;
      end
      if (cnt_dec)     cnt       <= cnt - 9'd1;
      if (do_commit)   wr_commit <= wr_tent;
      if (do_rollback) wr_tent   <= wr_commit;
      if (out_valid && out_ready) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Payload storage, no reset needed.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_tent[AW-1:0]] <= {(cnt == 9'd1), rx_data};
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_valid = (rd_ptr != wr_commit);
  // Gate with out_valid so the head reads as zero when nothing is pending.
  assign out_data  = out_valid ? head[7:0] : 8'h00;
  assign out_last  = out_valid & head[8];
  assign busy      = (state != S_HUNT);

endmodule

// File: tb/tb_serial_rx_packetizer.sv
// Directed self-checking bench for serial_rx_packetizer.
// Latency: n/a (testbench).
// Backpressure: drives out_ready in fixed, off and toggling patterns.
module tb_serial_rx_packetizer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_endofpacket = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       pkt_ok;
  logic       pkt_err;
  logic [1:0] err_code;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] rxq[$];
  int ok_cnt   = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  serial_rx_packetizer #(.SYNC_BYTE(8'hA5), .DEPTH(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_endofpacket (rx_endofpacket),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .pkt_ok         (pkt_ok),
    .pkt_err        (pkt_err),
    .err_code       (err_code),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so negedge sees what the next posedge samples.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) rxq.push_back({out_last, out_data});
      if (pkt_ok) ok_cnt++;
      if (pkt_err) err_cnt++;
      if (pkt_ok && pkt_err) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [7:0] base, input bit bad);
    logic [7:0] c;
    logic [7:0] b;
    c = len;
    send_byte(8'hA5);
    send_byte(len);
    for (int i = 0; i < int'(len); i++) begin
      b = base + 8'(i);
      send_byte(b);
      c = c + b;
    end
    send_byte(bad ? (c ^ 8'h01) : c);
  endtask

  task automatic clear_mon();
    rxq.delete();
    ok_cnt   = 0;
    err_cnt  = 0;
    both_cnt = 0;
  endtask

  initial begin
    logic [8:0] e;
    int nl;

    // Reset state
    idle(3);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_pkt_ok", pkt_ok, 0);
    check("rst_pkt_err", pkt_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_busy", busy, 0);
    idle(1);

    // Good frame: A5 03 11 22 33 69
    clear_mon();
    out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    check("good_pkt_ok", pkt_ok, 1);
    check("good_out_valid_with_ok", out_valid, 1);
    check("good_first_data", out_data, 8'h11);
    idle(8);
    check("good_nbytes", rxq.size(), 3);
    if (rxq.size() == 3) begin
      check("good_b0", rxq[0], {1'b0, 8'h11});
      check("good_b1", rxq[1], {1'b0, 8'h22});
      check("good_b2", rxq[2], {1'b1, 8'h33});
    end
    check("good_ok_cnt", ok_cnt, 1);
    check("good_err_code", err_code, 0);

    // Bad checksum: A5 02 10 20 00, then A5 01 7F 80
    clear_mon();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    send_byte(8'h20); send_byte(8'h00);
    check("badchk_pkt_err", pkt_err, 1);
    check("badchk_err_code", err_code, 2'b01);
    idle(5);
    check("badchk_no_output", rxq.size(), 0);
    check("badchk_ok_cnt", ok_cnt, 0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    idle(5);
    check("recover_nbytes", rxq.size(), 1);
    if (rxq.size() == 1) check("recover_b0", rxq[0], {1'b1, 8'h7F});

    // Overflow: 40 committed, then LEN=32 against 24 free
    clear_mon();
    out_ready = 1'b0;
    send_frame(8'd40, 8'h01, 1'b0);
    send_byte(8'hA5);
    send_byte(8'h20);
    check("ovf_pkt_err", pkt_err, 1);
    check("ovf_err_code", err_code, 2'b10);
    check("ovf_busy_drop", busy, 1);
    for (int i = 0; i < 32; i++) send_byte(8'(i));
    check("ovf_busy_before_last", busy, 1);
    send_byte(8'h00);
    check("ovf_busy_after_drop", busy, 0);
    out_ready = 1'b1;
    idle(60);
    check("ovf_nbytes", rxq.size(), 40);
    if (rxq.size() == 40) begin
      check("ovf_first", rxq[0], {1'b0, 8'h01});
      check("ovf_last", rxq[39], {1'b1, 8'h28});
    end
    check("ovf_ok_cnt", ok_cnt, 1);
    check("ovf_err_cnt", err_cnt, 1);

    // Gap abort: A5 04 01 02, then line gap
    clear_mon();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    rx_endofpacket = 1'b1;
    @(posedge clk);
    #1;
    rx_endofpacket = 1'b0;
    check("gap_pkt_err", pkt_err, 1);
    check("gap_err_code", err_code, 2'b11);
    check("gap_busy", busy, 0);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    check("len0_pkt_ok", pkt_ok, 1);
    idle(5);
    check("gap_len0_no_output", rxq.size(), 0);

    // LEN equal to DEPTH fits an empty buffer exactly
    clear_mon();
    out_ready = 1'b0;
    send_frame(8'd64, 8'h40, 1'b0);
    check("full_pkt_ok", pkt_ok, 1);
    out_ready = 1'b1;
    idle(70);
    check("full_nbytes", rxq.size(), 64);
    if (rxq.size() == 64) begin
      check("full_first", rxq[0], {1'b0, 8'h40});
      check("full_last", rxq[63], {1'b1, 8'h7F});
    end

    // Hunt and wrap: garbage before each of 10 frames, out_ready toggling
    clear_mon();
    out_ready = 1'b1;
    fork
      begin
        for (int f = 0; f < 10; f++) begin
          send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
          send_frame(8'd13, 8'(f * 16), 1'b0);
        end
      end
      begin
        repeat (400) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    idle(5);
    check("wrap_nbytes", rxq.size(), 130);
    nl = 0;
    if (rxq.size() == 130) begin
      for (int i = 0; i < 130; i++) begin
        e = {((i % 13) == 12), 8'((i / 13) * 16 + (i % 13))};
        check("wrap_byte", rxq[i], e);
        if (rxq[i][8]) nl++;
      end
    end
    check("wrap_last_cnt", nl, 10);
    check("wrap_ok_cnt", ok_cnt, 10);
    check("wrap_err_cnt", err_cnt, 0);
    check("wrap_ok_err_overlap", both_cnt, 0);

    // Reset with committed bytes pending and a frame mid-payload
    out_ready = 1'b0;
    send_frame(8'd2, 8'h01, 1'b0);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pkt_ok", pkt_ok, 0);
    check("midrst_pkt_err", pkt_err, 0);
    check("midrst_err_code", err_code, 0);
    rst = 1'b0;
    clear_mon();
    out_ready = 1'b1;
    idle(10);
    check("midrst_no_output", rxq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
